result_accum: RTL and testbench

RESULT_ACCUM -- requirements
Module: result_accum

---
 rtl/result_accum_pkg.sv | 15 +
 rtl/result_accum_accum_sat.sv | 31 +++
 rtl/result_accum.sv | 116 +++++++++++
 tb/tb_result_accum.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_accum_pkg.sv
// Shared types and default sizing for the result accumulator.
package result_accum_pkg;

   // Frame FSM: nothing held, partial frame held, finished frame presented.
   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StHold
   } state_t;

   localparam int unsigned DEF_DW   = 5;
   localparam int unsigned DEF_N    = 4;
   localparam int unsigned DEF_ACCW = 6;

endpackage

// File: rtl/result_accum_accum_sat.sv
// Combinational adder for the frame accumulator: one-bit-wide headroom add,
// sticky overflow, and the presented sum value.
// Build option RESULT_ACCUM_SAT_EN: clamp the presented sum to 2^ACCW-1 on overflow;
// otherwise the presented sum is the true sum modulo 2^ACCW.
module accum_sat
   import result_accum_pkg::*;
#(
   parameter int unsigned DW   = DEF_DW,
   parameter int unsigned ACCW = DEF_ACCW
) (
   input  logic [ACCW:0]   acc,
   input  logic [DW-1:0]   sample,
   input  logic            ovf_in,
   output logic [ACCW:0]   acc_next,
   output logic            ovf_next,
   output logic [ACCW-1:0] res
);

   // Add the sample, latch overflow once any partial sum passes 2^ACCW-1.
   always_comb begin
      acc_next = acc + {{(ACCW + 1 - DW){1'b0}}, sample};
      // Sticky: the headroom bit can wrap away on later adds for large N.
      ovf_next = ovf_in | acc_next[ACCW];
`ifdef RESULT_ACCUM_SAT_EN
      res = ovf_next ? {ACCW{1'b1}} : acc_next[ACCW-1:0];
`else
      res = acc_next[ACCW-1:0];
`endif
   end

endmodule

// File: rtl/result_accum.sv
// Frame accumulator: sums N unsigned samples (or a flushed partial frame) and
// presents sum, max, count and overflow through a valid/ready output handshake.
// Build option RESULT_ACCUM_SAT_EN selects a saturating out_sum (see accum_sat).
module result_accum
   import result_accum_pkg::*;
#(
   parameter int unsigned DW   = DEF_DW,
   parameter int unsigned N    = DEF_N,
   parameter int unsigned ACCW = DEF_ACCW,
   localparam int unsigned CW  = $clog2(N) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [ACCW-1:0] out_sum,
   output logic [DW-1:0]   out_max,
   output logic [CW-1:0]   out_cnt,
   output logic            out_ovf
);

   state_t          state;
   logic [ACCW:0]   acc;
   logic [ACCW:0]   acc_next;
   logic [DW-1:0]   max_val;
   logic [DW-1:0]   max_next;
   logic [DW-1:0]   add_val;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_next;
   logic            ovf;
   logic            ovf_next;
   logic [ACCW-1:0] res;
   logic            accept;
   logic            close_frame;

   // Handshake decode and next frame contents; a non-accepting cycle adds zero.
   always_comb begin
      in_ready    = (state != StHold);
      accept      = in_valid & in_ready;
      add_val     = accept ? in_data : '0;
      cnt_next    = cnt + {{(CW - 1){1'b0}}, accept};
      max_next    = (accept && (in_data > max_val)) ? in_data : max_val;
      // Flush only closes a frame that already holds samples (ACCUM state).
      close_frame = (state == StAccum) && ((cnt_next == CW'(N)) || flush);
   end

   accum_sat #(
      .DW   (DW),
      .ACCW (ACCW)
   ) u_accum_sat (
      .acc      (acc),
      .sample   (add_val),
      .ovf_in   (ovf),
      .acc_next (acc_next),
      .ovf_next (ovf_next),
      .res      (res)
   );

   // Frame FSM with registered result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         acc       <= '0;
         max_val   <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_max   <= '0;
         out_cnt   <= '0;
         out_ovf   <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (accept) begin
                  acc     <= acc_next;
                  max_val <= max_next;
                  cnt     <= cnt_next;
                  ovf     <= ovf_next;
                  state   <= StAccum;
               end
            end
            StAccum: begin
               acc     <= acc_next;
               max_val <= max_next;
               cnt     <= cnt_next;
               ovf     <= ovf_next;
               if (close_frame) begin
                  state     <= StHold;
                  out_valid <= 1'b1;
                  out_sum   <= res;
                  out_max   <= max_next;
                  out_cnt   <= cnt_next;
                  out_ovf   <= ovf_next;
               end
            end
            StHold: begin
               if (out_ready) begin
                  state     <= StIdle;
                  out_valid <= 1'b0;
                  acc       <= '0;
                  max_val   <= '0;
                  cnt       <= '0;
                  ovf       <= 1'b0;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_result_accum.sv
// Self-checking bench for result_accum (DW=5, N=4, ACCW=6).
module tb_result_accum;

   localparam int DW      = 5;
   localparam int N       = 4;
   localparam int ACCW    = 6;
   localparam int SUM_MAX = (1 << ACCW) - 1;

   typedef struct packed {
      logic [ACCW-1:0] sum;
      logic [DW-1:0]   max;
      logic [2:0]      cnt;
      logic            ovf;
   } frame_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [DW-1:0]   in_data = '0;
   logic            flush = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [ACCW-1:0] out_sum;
   logic [DW-1:0]   out_max;
   logic [2:0]      out_cnt;
   logic            out_ovf;

   frame_t sb[$];
   frame_t exp_f;
   frame_t got_f;
   int     n_checks = 0;
   int     n_fail   = 0;

   int            m_sum;
   int            m_cnt;
   logic [DW-1:0] m_max;
   bit            m_ovf;

   result_accum #(
      .DW   (DW),
      .N    (N),
      .ACCW (ACCW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_max   (out_max),
      .out_cnt   (out_cnt),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic model_clear();
      m_sum = 0;
      m_cnt = 0;
      m_max = '0;
      m_ovf = 1'b0;
   endtask

   task automatic model_accept(input logic [DW-1:0] d);
      m_sum += int'(d);
      m_cnt++;
      if (d > m_max) m_max = d;
      if (m_sum > SUM_MAX) m_ovf = 1'b1;
   endtask

   // Push the expected result for the frame the model currently holds.
   task automatic model_close();
      frame_t f;
      f.max = m_max;
      f.cnt = 3'(m_cnt);
      f.ovf = m_ovf;
`ifdef RESULT_ACCUM_SAT_EN
      f.sum = m_ovf ? ACCW'(SUM_MAX) : ACCW'(m_sum);
`else
      f.sum = ACCW'(m_sum);
`endif
      sb.push_back(f);
      model_clear();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle sample expected to be accepted (block is in IDLE/ACCUM).
   task automatic drive(input logic [DW-1:0] d, input bit fl);
      in_valid = 1'b1;
      in_data  = d;
      flush    = fl;
      model_accept(d);
      tick();
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_data   = 5'd31;
      flush     = 1'b1;
      out_ready = 1'b0;
      tick();
      tick();
      n_checks++;
      if ({out_valid, out_sum, out_max, out_cnt, out_ovf} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%b sum=%0d max=%0d cnt=%0d ovf=%b required all 0",
                  out_valid, out_sum, out_max, out_cnt, out_ovf);
      end
      rst       = 1'b0;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      model_clear();
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready);
      end
   endtask

   task automatic test_basic();
      drive(5'd1, 1'b0);
      drive(5'd2, 1'b0);
      drive(5'd3, 1'b0);
      drive(5'd4, 1'b0);
      model_close();
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_valid: out_valid=%b required 1", out_valid);
      end
      got_f = {out_sum, out_max, out_cnt, out_ovf};
      exp_f = sb.pop_front();
      n_checks++;
      if (got_f !== exp_f) begin
         n_fail++;
         $display("FAIL basic_frame: sum=%0d max=%0d cnt=%0d ovf=%b required sum=%0d max=%0d cnt=%0d ovf=%b",
                  got_f.sum, got_f.max, got_f.cnt, got_f.ovf, exp_f.sum, exp_f.max, exp_f.cnt, exp_f.ovf);
      end
      tick();
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL basic_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_overflow();
      logic [DW-1:0] vals [12];
      vals = '{5'd31, 5'd31, 5'd31, 5'd31,
               5'd31, 5'd31, 5'd1,  5'd0,
               5'd31, 5'd31, 5'd2,  5'd0};
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < N; i++) drive(vals[f*N+i], 1'b0);
         model_close();
         got_f = {out_sum, out_max, out_cnt, out_ovf};
         exp_f = sb.pop_front();
         n_checks++;
         if ({out_valid, got_f} !== {1'b1, exp_f}) begin
            n_fail++;
            $display("FAIL ovf_frame%0d: valid=%b sum=%0d max=%0d cnt=%0d ovf=%b required valid=1 sum=%0d max=%0d cnt=%0d ovf=%b",
                     f, out_valid, got_f.sum, got_f.max, got_f.cnt, got_f.ovf,
                     exp_f.sum, exp_f.max, exp_f.cnt, exp_f.ovf);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(5'd5, 1'b0);
      drive(5'd6, 1'b0);
      drive(5'd7, 1'b0);
      drive(5'd8, 1'b0);
      model_close();
      exp_f    = sb[0];
      in_valid = 1'b1;
      in_data  = 5'd9;
      for (int k = 0; k < 5; k++) begin
         got_f = {out_sum, out_max, out_cnt, out_ovf};
         n_checks++;
         if ({out_valid, in_ready, got_f} !== {2'b10, exp_f}) begin
            n_fail++;
            $display("FAIL hold_cycle%0d: valid=%b in_ready=%b sum=%0d max=%0d cnt=%0d required valid=1 in_ready=0 sum=%0d max=%0d cnt=%0d",
                     k, out_valid, in_ready, got_f.sum, got_f.max, got_f.cnt,
                     exp_f.sum, exp_f.max, exp_f.cnt);
         end
         tick();
      end
      out_ready = 1'b1;
      void'(sb.pop_front());
      tick();
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL hold_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      end
      // Sample 9 is taken only on this edge.
      model_accept(5'd9);
      tick();
      in_valid = 1'b0;
      drive(5'd1, 1'b0);
      drive(5'd1, 1'b0);
      drive(5'd1, 1'b0);
      model_close();
      got_f = {out_sum, out_max, out_cnt, out_ovf};
      exp_f = sb.pop_front();
      n_checks++;
      if ({out_valid, got_f} !== {1'b1, exp_f}) begin
         n_fail++;
         $display("FAIL held_sample_frame: valid=%b sum=%0d max=%0d cnt=%0d required valid=1 sum=%0d max=%0d cnt=%0d",
                  out_valid, got_f.sum, got_f.max, got_f.cnt, exp_f.sum, exp_f.max, exp_f.cnt);
      end
      tick();
   endtask

   task automatic test_flush();
      drive(5'd7, 1'b0);
      drive(5'd9, 1'b0);
      drive(5'd2, 1'b1);
      model_close();
      got_f = {out_sum, out_max, out_cnt, out_ovf};
      exp_f = sb.pop_front();
      n_checks++;
      if ({out_valid, got_f} !== {1'b1, exp_f}) begin
         n_fail++;
         $display("FAIL flush_with_sample: valid=%b sum=%0d max=%0d cnt=%0d required valid=1 sum=%0d max=%0d cnt=%0d",
                  out_valid, got_f.sum, got_f.max, got_f.cnt, exp_f.sum, exp_f.max, exp_f.cnt);
      end
      tick();
      // Flush with an empty frame is ignored.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle%0d: out_valid=%b required 0", k, out_valid);
         end
         tick();
      end
      // Flush alone on a one-sample frame.
      drive(5'd3, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      model_close();
      got_f = {out_sum, out_max, out_cnt, out_ovf};
      exp_f = sb.pop_front();
      n_checks++;
      if ({out_valid, got_f} !== {1'b1, exp_f}) begin
         n_fail++;
         $display("FAIL flush_partial: valid=%b sum=%0d max=%0d cnt=%0d required valid=1 sum=%0d max=%0d cnt=%0d",
                  out_valid, got_f.sum, got_f.max, got_f.cnt, exp_f.sum, exp_f.max, exp_f.cnt);
      end
      tick();
      // Flush on the Nth accept yields exactly one frame.
      drive(5'd1, 1'b0);
      drive(5'd1, 1'b0);
      drive(5'd1, 1'b0);
      drive(5'd1, 1'b1);
      model_close();
      got_f = {out_sum, out_max, out_cnt, out_ovf};
      exp_f = sb.pop_front();
      n_checks++;
      if ({out_valid, got_f} !== {1'b1, exp_f}) begin
         n_fail++;
         $display("FAIL flush_nth: valid=%b sum=%0d cnt=%0d required valid=1 sum=%0d cnt=%0d",
                  out_valid, got_f.sum, got_f.cnt, exp_f.sum, exp_f.cnt);
      end
      tick();
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_nth_single: out_valid=%b required 0", out_valid);
      end
      // Flush during HOLD is not remembered.
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) drive(5'd2, 1'b0);
      model_close();
      exp_f = sb.pop_front();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      out_ready = 1'b1;
      got_f = {out_sum, out_max, out_cnt, out_ovf};
      n_checks++;
      if ({out_valid, got_f} !== {1'b1, exp_f}) begin
         n_fail++;
         $display("FAIL flush_hold_stable: valid=%b sum=%0d cnt=%0d required valid=1 sum=%0d cnt=%0d",
                  out_valid, got_f.sum, got_f.cnt, exp_f.sum, exp_f.cnt);
      end
      tick();
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_hold_ignored: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      drive(5'd5, 1'b0);
      drive(5'd6, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_clear();
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL reset_accum_ready: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      end
      for (int i = 0; i < N; i++) drive(5'd1, 1'b0);
      model_close();
      got_f = {out_sum, out_max, out_cnt, out_ovf};
      exp_f = sb.pop_front();
      n_checks++;
      if ({out_valid, got_f} !== {1'b1, exp_f}) begin
         n_fail++;
         $display("FAIL reset_discard: valid=%b sum=%0d cnt=%0d required valid=1 sum=%0d cnt=%0d",
                  out_valid, got_f.sum, got_f.cnt, exp_f.sum, exp_f.cnt);
      end
      tick();
      // Reset while a result is pending discards it.
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) drive(5'd3, 1'b0);
      model_clear();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({out_valid, in_ready, out_sum, out_cnt} !== {2'b01, {ACCW{1'b0}}, 3'd0}) begin
         n_fail++;
         $display("FAIL reset_hold: valid=%b in_ready=%b sum=%0d cnt=%0d required 0 1 0 0",
                  out_valid, in_ready, out_sum, out_cnt);
      end
      out_ready = 1'b1;
   endtask

   initial begin
      model_clear();
      test_reset();
      test_basic();
      test_overflow();
      test_backpressure();
      test_flush();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
